disp_regctrl: RTL and testbench
===============================

# disp_regctrl

AXI4-Lite slave register block for the XGA display IP. It lets the CPU set the VRAM frame start address and the display-enable bit, read the VBLANK status flag, and clear that flag with write-1-to-clear. It sits directly downstream of the VBLANK flag stage, in the ACLK domain. It consumes `VBLANK`, produces the `CLR_VBLANK` pulse, and drives a level interrupt.

## Interface
- `ADDR_W`, default 4: AXI address width; offsets are decoded from `AWADDR/ARADDR[3:2]`.
- `ACLK`  in  1  clock.
- `ARST`  in  1  reset, synchronous, active-high.
- `S_AXI_AWADDR`  in  `ADDR_W`  write address.
- `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write-address handshake.
- `S_AXI_WDATA`  in  32  write data.
- `S_AXI_WSTRB`  in  4  byte strobes.
- `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write-data handshake.
- `S_AXI_BRESP`  out  2  write response; always `2'b00`.
- `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write-response handshake.
- `S_AXI_ARADDR`  in  `ADDR_W`  read address.
- `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read-address handshake.
- `S_AXI_RDATA`  out  32  read data.
- `S_AXI_RRESP`  out  2  read response; always `2'b00`.
- `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read-data handshake.
- `VBLANK`  in  1  sticky VBLANK flag from the flag stage.
- `CLR_VBLANK`  out  1  one-cycle clear pulse to the flag stage.
- `DISPADDR`  out  32  VRAM frame start address.
- `DISPON`  out  1  display enable.
- `IRQ`  out  1  `VBLANK & INTEN`, registered.

## Operation
Register map:
- `0x0` DISPADDR: RW. Bits [5:0] are hardwired to 0 (64-byte alignment).
- `0x4` DISPCTRL: bit0 is DISPON (RW); other bits read 0.
- `0x8` DISPINT: bit0 reads `VBLANK`. Writing 1 to bit0 with `WSTRB[0]` set pulses `CLR_VBLANK`. Writing 0 has no effect.
- `0xC` INTEN: bit0 is RW; other bits read 0.
- Writes honour `WSTRB` per byte.
- `BRESP` and `RRESP` are always OKAY.
- Writes to unmapped bits are ignored.

Write FSM:
- States: `WR_IDLE`, `WR_WAIT_W` (AW taken), `WR_WAIT_AW` (W taken), `WR_RESP`.
- `AWREADY` = 1 in `WR_IDLE` and `WR_WAIT_AW`.
- `WREADY` = 1 in `WR_IDLE` and `WR_WAIT_W`.
- AW and W may arrive together, in either order, or separately. Address and data are latched at their respective handshakes.
- The write commits on the edge after the completing handshake. `BVALID` rises at that same edge, then the FSM holds in `WR_RESP` until `BREADY`, then returns to `WR_IDLE`.

Read FSM:
- States: `RD_IDLE` and `RD_DATA`.
- `ARREADY` = 1 in `RD_IDLE`.
- At the AR handshake edge, `RDATA` is registered from current register and `VBLANK` values, and `RVALID` goes to 1.
- `RDATA` and `RVALID` are held until `RREADY`.

Read and write channels are independent and may be active in the same cycle.

## Timing
- Reset values: `DISPADDR` = 0, `DISPON` = 0, INTEN = 0, `CLR_VBLANK` = 0, `IRQ` = 0, `BVALID` = 0, `RVALID` = 0, `RDATA` = 0. FSMs reset to IDLE, so `AWREADY`, `WREADY` and `ARREADY` are 1 in the first cycle after reset.
- Write commit: registers update and `CLR_VBLANK` is high for exactly one ACLK cycle, one cycle after the completing handshake.
- `IRQ` lags `VBLANK`/INTEN by one cycle.
- `VBLANK` falls one cycle after the `CLR_VBLANK` pulse, because the flag stage registers it. `IRQ` falls one cycle after that.
- Clear and a new VBLANK edge in the same cycle: clear wins in the flag stage, so that frame's flag is lost. This is accepted behaviour; the test bench models it.
- Read racing a write to the same register: the read returns the pre-commit value if its AR handshake edge is at or before the commit edge.
- Back-to-back: with `BREADY`/`RREADY` held high, sustained throughput is one write per 2 cycles and one read per 2 cycles.
- `ARST` mid-transaction: outstanding responses are dropped and all registers return to reset values. `CLR_VBLANK` is forced to 0.

## Structure
- Package `disp_regs_pkg` holds:
  - offset constants `OFS_DISPADDR`, `OFS_DISPCTRL`, `OFS_DISPINT`, `OFS_INTEN`;
  - `wr_state_t` and `rd_state_t` enums;
  - the `RESP_OKAY` constant.
- No sub-module. Both FSMs live in one module; a separate byte-strobe merge function in the package is sufficient.

## Test plan
- Reset: after `ARST`, all outputs are at their reset values, `AWREADY`/`WREADY`/`ARREADY` = 1, and reading `0x0` returns 0.
- Write `0x0` = `0x1234_5678` with AW and W in the same cycle, then read back -> `0x1234_5640`, `BRESP` = 0, and `DISPADDR` updates one cycle after the handshake.
- W sent 3 cycles before AW; write `0x4` = `0xFFFF_FFFF` with `WSTRB` = `4'b0001` -> `DISPON` = 1, read gives `0x0000_0001`. A second write with `WSTRB` = `4'b0010` leaves `DISPON` unchanged.
- Drive `VBLANK` = 1 with INTEN = 1 -> `IRQ` = 1 after 1 cycle, and reading `0x8` gives 1. Write `0x8` = 1 -> exactly one `CLR_VBLANK` pulse. With a flag-stage model, `IRQ` falls 2 cycles later.
- Write `0x8` = 0 -> no `CLR_VBLANK` pulse. Write `0x8` = 1 with `WSTRB` = 0 -> no pulse.
- Hold `BREADY`/`RREADY` low for 5 cycles -> `BVALID`/`RVALID`/`RDATA` stay stable and ready signals stay low. Assert `ARST` during the hold -> everything returns to reset values.

Source files
------------

// File: rtl/disp_regctrl_pkg.sv
// Shared definitions for the XGA display register block: register offsets,
// channel FSM state types, response codes and the byte-strobe merge helper.
package disp_regs_pkg;

  // Register word index, taken from address bits [3:2]
  localparam logic [1:0] OFS_DISPADDR = 2'd0;
  localparam logic [1:0] OFS_DISPCTRL = 2'd1;
  localparam logic [1:0] OFS_DISPINT  = 2'd2;
  localparam logic [1:0] OFS_INTEN    = 2'd3;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [31:0] DISPADDR_MASK = 32'hFFFF_FFC0;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_regctrl.sv
// AXI4-Lite register block for the XGA display IP: frame address, display
// enable, VBLANK status with write-1-to-clear, and the VBLANK interrupt.
module disp_regctrl
  import disp_regs_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  input  logic              VBLANK,
  output logic              CLR_VBLANK,
  output logic [31:0]       DISPADDR,
  output logic              DISPON,
  output logic              IRQ
);

  wr_state_t   wr_state_r;
  rd_state_t   rd_state_r;
  logic [1:0]  aw_idx_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        awready_r;
  logic        wready_r;
  logic        bvalid_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [31:0] dispaddr_r;
  logic        dispon_r;
  logic        inten_r;
  logic        clr_vblank_r;
  logic        irq_r;

  logic        wr_en_s;
  logic [1:0]  wr_idx_s;
  logic [31:0] wr_data_s;
  logic [3:0]  wr_strb_s;
  logic [31:0] rd_mux_s;
  logic        unused_s;

  // Only bits [3:2] of the addresses select a register
  assign unused_s = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  // Pick address/data for the handshake that completes a write this cycle
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = S_AXI_AWADDR[3:2];
    wr_data_s = S_AXI_WDATA;
    wr_strb_s = S_AXI_WSTRB;
    case (wr_state_r)
      WR_IDLE: begin
        wr_en_s = S_AXI_AWVALID & S_AXI_WVALID;
      end
      WR_WAIT_W: begin
        wr_en_s  = S_AXI_WVALID;
        wr_idx_s = aw_idx_r;
      end
      WR_WAIT_AW: begin
        wr_en_s   = S_AXI_AWVALID;
        wr_data_s = wdata_r;
        wr_strb_s = wstrb_r;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Write channel FSM with registered ready/valid outputs
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_state_r <= WR_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      aw_idx_r   <= 2'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (wr_en_s) begin
            wr_state_r <= WR_RESP;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b1;
          end else if (S_AXI_AWVALID) begin
            wr_state_r <= WR_WAIT_W;
            aw_idx_r   <= S_AXI_AWADDR[3:2];
            awready_r  <= 1'b0;
          end else if (S_AXI_WVALID) begin
            wr_state_r <= WR_WAIT_AW;
            wdata_r    <= S_AXI_WDATA;
            wstrb_r    <= S_AXI_WSTRB;
            wready_r   <= 1'b0;
          end
        end
        WR_WAIT_W: begin
          if (wr_en_s) begin
            wr_state_r <= WR_RESP;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b1;
          end
        end
        WR_WAIT_AW: begin
          if (wr_en_s) begin
            wr_state_r <= WR_RESP;
            awready_r  <= 1'b0;
            bvalid_r   <= 1'b1;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state_r <= WR_IDLE;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
          awready_r  <= 1'b1;
          wready_r   <= 1'b1;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register file, clear pulse and interrupt
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      dispaddr_r   <= 32'd0;
      dispon_r     <= 1'b0;
      inten_r      <= 1'b0;
      clr_vblank_r <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      clr_vblank_r <= 1'b0;
      irq_r        <= VBLANK & inten_r;
      if (wr_en_s) begin
        case (wr_idx_s)
          OFS_DISPADDR: dispaddr_r <= merge_bytes(dispaddr_r, wr_data_s, wr_strb_s) & DISPADDR_MASK;
          OFS_DISPCTRL: if (wr_strb_s[0]) dispon_r <= wr_data_s[0];
          OFS_DISPINT:  clr_vblank_r <= wr_strb_s[0] & wr_data_s[0];
          OFS_INTEN:    if (wr_strb_s[0]) inten_r <= wr_data_s[0];
          default:      clr_vblank_r <= 1'b0;
        endcase
      end
    end
  end

  // Read data selection from current register state
  always_comb begin
    rd_mux_s = 32'd0;
    case (S_AXI_ARADDR[3:2])
      OFS_DISPADDR: rd_mux_s = dispaddr_r;
      OFS_DISPCTRL: rd_mux_s = {31'd0, dispon_r};
      OFS_DISPINT:  rd_mux_s = {31'd0, VBLANK};
      OFS_INTEN:    rd_mux_s = {31'd0, inten_r};
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Read channel FSM; RDATA is captured at the AR handshake and held
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (S_AXI_ARVALID) begin
            rd_state_r <= RD_DATA;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rdata_r    <= rd_mux_s;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
          arready_r  <= 1'b1;
          rvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign CLR_VBLANK    = clr_vblank_r;
  assign DISPADDR      = dispaddr_r;
  assign DISPON        = dispon_r;
  assign IRQ           = irq_r;

endmodule

// File: tb/tb_disp_regctrl.sv
// Self-checking bench for disp_regctrl with a VBLANK flag-stage model and
// response scoreboards for the B and R channels.
`timescale 1ns/1ps
module tb_disp_regctrl;
  import disp_regs_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [3:0]  S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        VBLANK;
  logic        CLR_VBLANK;
  logic [31:0] DISPADDR;
  logic        DISPON;
  logic        IRQ;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] m_dispaddr;
  logic        m_dispon;
  logic        m_inten;
  logic        vblank_r;
  logic        vblank_set;
  int          clr_cnt = 0;

  always #5 ACLK = ~ACLK;

  disp_regctrl #(.ADDR_W(4)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .VBLANK(VBLANK),
    .CLR_VBLANK(CLR_VBLANK), .DISPADDR(DISPADDR), .DISPON(DISPON), .IRQ(IRQ)
  );

  // Flag stage: clear has priority over a new VBLANK edge
  always @(posedge ACLK) begin
    if (ARST) vblank_r <= 1'b0;
    else if (CLR_VBLANK) vblank_r <= 1'b0;
    else if (vblank_set) vblank_r <= 1'b1;
  end
  assign VBLANK = vblank_r;

  always @(negedge ACLK) begin
    if (CLR_VBLANK === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0: return S_AXI_AWREADY;
      1: return S_AXI_WREADY;
      2: return S_AXI_ARREADY;
      3: return S_AXI_BVALID;
      default: return S_AXI_RVALID;
    endcase
  endfunction

  task automatic wait_high(input int sel, input string name);
    int n = 0;
    while (sig_sel(sel) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sig_sel(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s: timeout, got %b required 1", name, sig_sel(sel));
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0: return m_dispaddr;
      2'd1: return {31'd0, m_dispon};
      2'd2: return {31'd0, VBLANK};
      default: return {31'd0, m_inten};
    endcase
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    case (addr[3:2])
      2'd0: begin
        for (int b = 0; b < 4; b++) if (strb[b]) m_dispaddr[8*b +: 8] = data[8*b +: 8];
        m_dispaddr[5:0] = 6'd0;
      end
      2'd1: if (strb[0]) m_dispon = data[0];
      2'd3: if (strb[0]) m_inten = data[0];
      default: ;
    endcase
  endtask

  task automatic collect_b(input string name);
    logic [1:0] exp_resp;
    wait_high(3, name);
    exp_resp = b_q.pop_front();
    checks++;
    if (S_AXI_BRESP !== exp_resp) begin
      errors++;
      $display("FAIL %s_bresp: got %b required %b", name, S_AXI_BRESP, exp_resp);
    end
    tick();
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead);
    b_q.push_back(RESP_OKAY);
    if (w_lead > 0) begin
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      wait_high(1, "wready");
      tick();
      S_AXI_WVALID = 1'b0;
      repeat (w_lead - 1) tick();
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      wait_high(0, "awready");
      tick();
      S_AXI_AWVALID = 1'b0;
    end else begin
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      wait_high(0, "awready");
      wait_high(1, "wready");
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
    model_write(addr, data, strb);
    collect_b("write");
  endtask

  task automatic do_read(input logic [3:0] addr, input string name);
    logic [31:0] exp_data;
    rd_q.push_back(model_read(addr));
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    wait_high(2, "arready");
    tick();
    S_AXI_ARVALID = 1'b0;
    wait_high(4, "rvalid");
    exp_data = rd_q.pop_front();
    checks++;
    if (S_AXI_RDATA !== exp_data || S_AXI_RRESP !== RESP_OKAY) begin
      errors++;
      $display("FAIL %s: got rdata=%h rresp=%b required rdata=%h rresp=00",
               name, S_AXI_RDATA, S_AXI_RRESP, exp_data);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
         CLR_VBLANK, IRQ, DISPON} !== 8'b1110_0000) begin
      errors++;
      $display("FAIL %s_ctl: got %b required 11100000", name,
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                CLR_VBLANK, IRQ, DISPON});
    end
    checks++;
    if (DISPADDR !== 32'd0 || S_AXI_RDATA !== 32'd0) begin
      errors++;
      $display("FAIL %s_data: got dispaddr=%h rdata=%h required 0/0", name, DISPADDR, S_AXI_RDATA);
    end
  endtask

  task automatic test_reset();
    ARST = 1'b1;
    repeat (3) tick();
    ARST = 1'b0;
    m_dispaddr = 32'd0; m_dispon = 1'b0; m_inten = 1'b0;
    check_reset_outputs("reset");
    do_read(4'h0, "reset_read0");
  endtask

  task automatic test_dispaddr();
    b_q.push_back(RESP_OKAY);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    checks++;
    if (DISPADDR !== 32'd0) begin
      errors++; $display("FAIL dispaddr_pre: got %h required 00000000", DISPADDR);
    end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(4'h0, 32'h1234_5678, 4'hF);
    checks++;
    if (DISPADDR !== 32'h1234_5640) begin
      errors++; $display("FAIL dispaddr_commit: got %h required 12345640", DISPADDR);
    end
    collect_b("dispaddr");
    do_read(4'h0, "dispaddr_read");
  endtask

  task automatic test_dispctrl_strobes();
    do_write(4'h4, 32'hFFFF_FFFF, 4'b0001, 3);
    checks++;
    if (DISPON !== 1'b1) begin
      errors++; $display("FAIL dispon_set: got %b required 1", DISPON);
    end
    do_read(4'h4, "dispctrl_read");
    do_write(4'h4, 32'h0000_0000, 4'b0010, 0);
    checks++;
    if (DISPON !== 1'b1) begin
      errors++; $display("FAIL dispon_strobe: got %b required 1", DISPON);
    end
    do_read(4'h4, "dispctrl_read2");
    do_read(4'hC, "inten_read0");
  endtask

  task automatic test_irq_clear();
    int c0;
    do_write(4'hC, 32'h0000_0001, 4'h1, 0);
    vblank_set = 1'b1;
    tick();
    vblank_set = 1'b0;
    checks++;
    if (VBLANK !== 1'b1 || IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_lag: got vblank=%b irq=%b required 1/0", VBLANK, IRQ);
    end
    tick();
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b required 1", IRQ);
    end
    do_read(4'h8, "dispint_read");
    c0 = clr_cnt;
    do_write(4'h8, 32'h0000_0001, 4'hF, 0);
    checks++;
    if (VBLANK !== 1'b0 || IRQ !== 1'b1) begin
      errors++; $display("FAIL clr_vblank_fall: got vblank=%b irq=%b required 0/1", VBLANK, IRQ);
    end
    tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_fall: got %b required 0", IRQ);
    end
    tick();
    checks++;
    if (clr_cnt - c0 !== 1) begin
      errors++; $display("FAIL clr_pulse_count: got %0d required 1", clr_cnt - c0);
    end
  endtask

  task automatic test_no_clear();
    int c0;
    vblank_set = 1'b1;
    tick();
    vblank_set = 1'b0;
    c0 = clr_cnt;
    do_write(4'h8, 32'h0000_0000, 4'hF, 0);
    do_write(4'h8, 32'h0000_0001, 4'h0, 0);
    tick();
    checks++;
    if (clr_cnt - c0 !== 0 || VBLANK !== 1'b1 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL no_clear: got pulses=%0d vblank=%b irq=%b required 0/1/1",
               clr_cnt - c0, VBLANK, IRQ);
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] exp_rd;
    logic [1:0]  exp_b;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    b_q.push_back(RESP_OKAY);
    rd_q.push_back(model_read(4'h0));
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hAABB_CCDD; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'h0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model_write(4'h0, 32'hAABB_CCDD, 4'hF);
    exp_rd = rd_q.pop_front();
    exp_b  = b_q.pop_front();
    checks++;
    if (DISPADDR !== 32'hAABB_CCC0) begin
      errors++; $display("FAIL race_commit: got %h required aabbccc0", DISPADDR);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_rd ||
          S_AXI_BRESP !== exp_b) begin
        errors++;
        $display("FAIL hold_resp[%0d]: got b=%b r=%b rdata=%h required 1/1/%h",
                 i, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, exp_rd);
      end
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
        errors++;
        $display("FAIL hold_ready[%0d]: got %b required 000", i,
                 {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      tick();
    end
    ARST = 1'b1;
    tick();
    ARST = 1'b0;
    m_dispaddr = 32'd0; m_dispon = 1'b0; m_inten = 1'b0;
    check_reset_outputs("midreset");
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    do_read(4'h0, "midreset_read0");
  endtask

  task automatic test_back_to_back();
    int nw = 0;
    int nr = 0;
    logic [31:0] exp_v;
    S_AXI_AWADDR = 4'h0; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'h4;
    S_AXI_WDATA = 32'h1111_1111;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (S_AXI_AWREADY && S_AXI_WREADY) begin
        nw++;
        model_write(4'h0, S_AXI_WDATA, 4'hF);
        b_q.push_back(RESP_OKAY);
      end
      if (S_AXI_ARREADY) begin
        nr++;
        rd_q.push_back(model_read(4'h4));
      end
      tick();
      S_AXI_WDATA = 32'h1111_1111 * (nw + 1);
      if (S_AXI_BVALID === 1'b1 && b_q.size() > 0) begin
        exp_v = {30'd0, b_q.pop_front()};
        checks++;
        if ({30'd0, S_AXI_BRESP} !== exp_v) begin
          errors++; $display("FAIL b2b_bresp: got %b required %b", S_AXI_BRESP, exp_v[1:0]);
        end
      end
      if (S_AXI_RVALID === 1'b1 && rd_q.size() > 0) begin
        exp_v = rd_q.pop_front();
        checks++;
        if (S_AXI_RDATA !== exp_v) begin
          errors++; $display("FAIL b2b_rdata: got %h required %h", S_AXI_RDATA, exp_v);
        end
      end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++;
    if (nw !== 4 || nr !== 4 || b_q.size() !== 0 || rd_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_throughput: got writes=%0d reads=%0d pending=%0d/%0d required 4/4/0/0",
               nw, nr, b_q.size(), rd_q.size());
    end
    tick();
    checks++;
    if (DISPADDR !== m_dispaddr) begin
      errors++; $display("FAIL b2b_dispaddr: got %h required %h", DISPADDR, m_dispaddr);
    end
  endtask

  initial begin
    ARST = 1'b1;
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    vblank_set = 1'b0;
    m_dispaddr = 32'd0; m_dispon = 1'b0; m_inten = 1'b0;
    test_reset();
    test_dispaddr();
    test_dispctrl_strobes();
    test_irq_clear();
    test_no_clear();
    test_backpressure_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
